multicycle_ctrl_fsm: RTL and testbench

//  Parametrised multi-cycle control sequencer for the RV32I datapath; successor to the single-cycle control path.

---
 rtl/rv_ctrl_pkg.sv | 67 ++++++
 rtl/multicycle_ctrl_fsm_if.sv | 41 ++++
 rtl/multicycle_ctrl_fsm_alu_decoder.sv | 41 ++++
 rtl/multicycle_ctrl_fsm.sv | 256 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control path: sequencer states,
// base opcodes, ALUControl encodings, fault codes and a branch helper.
package rv_ctrl_pkg;

  // Sequencer states; ST_TRAP is terminal until reset.
  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_WB_ALU   = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_WB_MEM   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_TRAP     = 4'd11
  } state_e;

  // Base opcodes handled by the sequencer.
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ALUControl encodings understood by the shared ALU.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  // Datapath mux selects.
  localparam logic [1:0] SRC_B_RS2     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;

  // Sticky fault reasons.
  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_ILLEGAL = 2'b01,
    FAULT_TIMEOUT = 2'b10
  } fault_e;

  // What the ALU is being used for in a given state.
  typedef enum logic [1:0] {
    ALU_CLS_ADD = 2'd0,
    ALU_CLS_SUB = 2'd1,
    ALU_CLS_R   = 2'd2,
    ALU_CLS_I   = 2'd3
  } alu_cls_e;

  // BEQ/BNE outcome from the ALU zero flag; other funct3 values never take.
  function automatic logic br_taken(input logic [2:0] funct3, input logic zero);
    return ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control/datapath bundle between the multi-cycle sequencer (master) and the
// RV32I datapath plus memory port (slave).
//
// Memory handshake: mem_req is the request valid, mem_ready is the ready.
// A transfer completes on a rising clk edge where mem_req=1 and mem_ready=1.
// While mem_req=1 and mem_ready=0 the master keeps mem_req, mem_we and IorD
// unchanged; mem_ready seen while mem_req=0 has no effect.
interface multicycle_ctrl_fsm_if #(
  parameter int ALU_CTRL_W = 4,
  parameter int RET_CNT_W  = 32
);
  logic [31:0]           instruction;
  logic                  zero_flag;
  logic                  mem_ready;
  logic                  mem_req;
  logic                  mem_we;
  logic                  IorD;
  logic                  ir_write;
  logic                  pc_write;
  logic [1:0]            pc_src;
  logic                  alu_src_a;
  logic [1:0]            alu_src_b;
  logic [ALU_CTRL_W-1:0] ALUControl;
  logic                  RegWrite;
  logic                  MemtoReg;
  logic                  fault;
  logic [1:0]            fault_code;
  logic [RET_CNT_W-1:0]  retired;

  modport master (
    input  instruction, zero_flag, mem_ready,
    output mem_req, mem_we, IorD, ir_write, pc_write, pc_src, alu_src_a,
           alu_src_b, ALUControl, RegWrite, MemtoReg, fault, fault_code, retired
  );

  modport slave (
    output instruction, zero_flag, mem_ready,
    input  mem_req, mem_we, IorD, ir_write, pc_write, pc_src, alu_src_a,
           alu_src_b, ALUControl, RegWrite, MemtoReg, fault, fault_code, retired
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_alu_decoder.sv
// Combinational ALUControl selection from the ALU usage class, funct3 and
// instruction bit 30.
module alu_decoder
  import rv_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  alu_cls_e              op_class,
  input  logic [2:0]            funct3,
  input  logic                  bit30,
  output logic [ALU_CTRL_W-1:0] alu_ctrl
);

  logic [3:0] code;

  // Bit 30 selects SUB only for R-type; for shifts right it selects SRA in
  // both R and I forms, elsewhere in I-type it is just an immediate bit.
  // SLTU has no dedicated encoding, so it shares the SLT operation.
  always_comb begin
    code = ALU_ADD;
    case (op_class)
      ALU_CLS_ADD: code = ALU_ADD;
      ALU_CLS_SUB: code = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  code = ((op_class == ALU_CLS_R) && bit30) ? ALU_SUB : ALU_ADD;
          3'b001:  code = ALU_SLL;
          3'b010:  code = ALU_SLT;
          3'b011:  code = ALU_SLT;
          3'b100:  code = ALU_XOR;
          3'b101:  code = bit30 ? ALU_SRA : ALU_SRL;
          3'b110:  code = ALU_OR;
          default: code = ALU_AND;
        endcase
      end
    endcase
  end

  assign alu_ctrl = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB over one
// shared ALU and memory port, with wait-state timeout, illegal-opcode trap
// and a retired-instruction counter.
module multicycle_ctrl_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W  = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_CNT_W   = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  multicycle_ctrl_fsm_if.master        bus,
  output state_e                       state_dbg
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e                state_q, state_n;
  fault_e                trap_code_n;
  logic                  retire_n;

  logic                  mem_req_q, mem_we_q, iord_q;
  logic                  pc_write_q;
  logic [1:0]            pc_src_q;
  logic                  alu_src_a_q;
  logic [1:0]            alu_src_b_q;
  logic [ALU_CTRL_W-1:0] alu_ctrl_q;
  logic                  reg_write_q, mem_to_reg_q;
  logic                  fault_q;
  fault_e                fault_code_q;
  logic [RET_CNT_W-1:0]  retired_q;
  logic [WAIT_W-1:0]     wait_cnt_q;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic                  mem_done, mem_wait, mem_timeout, br_take;
  alu_cls_e              alu_cls_n;
  logic [ALU_CTRL_W-1:0] alu_ctrl_n;
  logic                  unused_instr_bits;

  assign opcode = bus.instruction[6:0];
  assign funct3 = bus.instruction[14:12];
  assign unused_instr_bits = ^{bus.instruction[31], bus.instruction[29:15],
                               bus.instruction[11:7]};

  // A transfer only exists while our own request is up.
  assign mem_done    = mem_req_q && bus.mem_ready;
  assign mem_wait    = mem_req_q && !bus.mem_ready;
  assign mem_timeout = mem_wait && (wait_cnt_q == WAIT_LAST);
  assign br_take     = br_taken(funct3, bus.zero_flag);

  // Next state, trap reason on entry to TRAP, and retire on final-state exit.
  always_comb begin
    state_n     = state_q;
    trap_code_n = FAULT_NONE;
    retire_n    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (mem_done) begin
          state_n = ST_DECODE;
        end else if (mem_timeout) begin
          state_n     = ST_TRAP;
          trap_code_n = FAULT_TIMEOUT;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_R:         state_n = ST_EXEC_R;
          OP_I:         state_n = ST_EXEC_I;
          OP_LW, OP_SW: state_n = ST_MEM_ADDR;
          OP_BR:        state_n = ST_BRANCH;
          OP_JAL:       state_n = ST_JAL;
          default: begin
            state_n     = ST_TRAP;
            trap_code_n = FAULT_ILLEGAL;
          end
        endcase
      end
      ST_EXEC_R, ST_EXEC_I: state_n = ST_WB_ALU;
      ST_MEM_ADDR: state_n = bus.instruction[5] ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (mem_done) begin
          state_n = ST_WB_MEM;
        end else if (mem_timeout) begin
          state_n     = ST_TRAP;
          trap_code_n = FAULT_TIMEOUT;
        end
      end
      ST_MEM_WR: begin
        if (mem_done) begin
          state_n  = ST_FETCH;
          retire_n = 1'b1;
        end else if (mem_timeout) begin
          state_n     = ST_TRAP;
          trap_code_n = FAULT_TIMEOUT;
        end
      end
      ST_WB_ALU, ST_WB_MEM, ST_JAL: begin
        state_n  = ST_FETCH;
        retire_n = 1'b1;
      end
      ST_BRANCH: begin
        if ((funct3 == 3'b000) || (funct3 == 3'b001)) begin
          state_n  = ST_FETCH;
          retire_n = 1'b1;
        end else begin
          state_n     = ST_TRAP;
          trap_code_n = FAULT_ILLEGAL;
        end
      end
      ST_TRAP: state_n = ST_TRAP;
      default: begin
        state_n     = ST_TRAP;
        trap_code_n = FAULT_ILLEGAL;
      end
    endcase
  end

  // ALU usage for the state being entered, so ALUControl can be registered.
  always_comb begin
    alu_cls_n = ALU_CLS_ADD;
    case (state_n)
      ST_EXEC_R: alu_cls_n = ALU_CLS_R;
      ST_EXEC_I: alu_cls_n = ALU_CLS_I;
      ST_BRANCH: alu_cls_n = ALU_CLS_SUB;
      default:   alu_cls_n = ALU_CLS_ADD;
    endcase
  end

  alu_decoder #(
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_alu_decoder (
    .op_class (alu_cls_n),
    .funct3   (funct3),
    .bit30    (bus.instruction[30]),
    .alu_ctrl (alu_ctrl_n)
  );

  // State register plus Moore outputs registered from the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_FETCH;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      iord_q       <= 1'b0;
      pc_write_q   <= 1'b0;
      pc_src_q     <= PC_SRC_ALU;
      alu_src_a_q  <= 1'b0;
      alu_src_b_q  <= SRC_B_RS2;
      alu_ctrl_q   <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FAULT_NONE;
    end else begin
      state_q      <= state_n;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      iord_q       <= 1'b0;
      pc_write_q   <= 1'b0;
      pc_src_q     <= PC_SRC_ALU;
      alu_src_a_q  <= 1'b0;
      alu_src_b_q  <= SRC_B_RS2;
      alu_ctrl_q   <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      case (state_n)
        ST_FETCH: begin
          mem_req_q   <= 1'b1;
          alu_src_b_q <= SRC_B_FOUR;
          alu_ctrl_q  <= alu_ctrl_n;
        end
        ST_DECODE: begin
          alu_src_b_q <= SRC_B_IMM;
          alu_ctrl_q  <= alu_ctrl_n;
        end
        ST_EXEC_R: begin
          alu_src_a_q <= 1'b1;
          alu_ctrl_q  <= alu_ctrl_n;
        end
        ST_EXEC_I, ST_MEM_ADDR: begin
          alu_src_a_q <= 1'b1;
          alu_src_b_q <= SRC_B_IMM;
          alu_ctrl_q  <= alu_ctrl_n;
        end
        ST_WB_ALU: reg_write_q <= 1'b1;
        ST_MEM_RD: begin
          mem_req_q <= 1'b1;
          iord_q    <= 1'b1;
        end
        ST_WB_MEM: begin
          reg_write_q  <= 1'b1;
          mem_to_reg_q <= 1'b1;
        end
        ST_MEM_WR: begin
          mem_req_q <= 1'b1;
          iord_q    <= 1'b1;
          mem_we_q  <= 1'b1;
        end
        ST_BRANCH: begin
          alu_src_a_q <= 1'b1;
          pc_src_q    <= PC_SRC_ALUOUT;
          alu_ctrl_q  <= alu_ctrl_n;
        end
        ST_JAL: begin
          pc_write_q  <= 1'b1;
          pc_src_q    <= PC_SRC_ALUOUT;
          reg_write_q <= 1'b1;
        end
        default: ;
      endcase
      if ((state_n == ST_TRAP) && (state_q != ST_TRAP)) begin
        fault_q      <= 1'b1;
        fault_code_q <= trap_code_n;
      end
    end
  end

  // Wait-state counter (cleared whenever no request is stalled) and
  // retired-instruction counter (wraps naturally).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      retired_q  <= '0;
    end else begin
      if (mem_wait) wait_cnt_q <= wait_cnt_q + 1'b1;
      else          wait_cnt_q <= '0;
      if (retire_n) retired_q <= retired_q + 1'b1;
    end
  end

  // IR latch and PC update must coincide with the completing memory beat and
  // with the branch compare result, so these strobes are qualified by the
  // current mem_ready/zero_flag on top of registered state.
  assign bus.ir_write = (state_q == ST_FETCH) && mem_done;
  assign bus.pc_write = ((state_q == ST_FETCH) && mem_done) ||
                        ((state_q == ST_BRANCH) && br_take) ||
                        pc_write_q;

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.IorD       = iord_q;
  assign bus.pc_src     = pc_src_q;
  assign bus.alu_src_a  = alu_src_a_q;
  assign bus.alu_src_b  = alu_src_b_q;
  assign bus.ALUControl = alu_ctrl_q;
  assign bus.RegWrite   = reg_write_q;
  assign bus.MemtoReg   = mem_to_reg_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = fault_code_q;
  assign bus.retired    = retired_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm with a 4-bit retired counter so the
// wrap can be reached quickly.
module tb_multicycle_ctrl_fsm;
  import rv_ctrl_pkg::*;

  localparam int ALU_W = 4;
  localparam int TMO   = 16;
  localparam int RW    = 4;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_ADDI = 32'h00108093;
  localparam logic [31:0] I_LW   = 32'h00012083;
  localparam logic [31:0] I_SW   = 32'h00112023;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_BNE  = 32'h00209063;
  localparam logic [31:0] I_BBAD = 32'h0020A063;
  localparam logic [31:0] I_JAL  = 32'h000000EF;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset;
  state_e state_dbg;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if #(.ALU_CTRL_W(ALU_W), .RET_CNT_W(RW)) bus ();

  multicycle_ctrl_fsm #(
    .ALU_CTRL_W  (ALU_W),
    .MEM_TIMEOUT (TMO),
    .RET_CNT_W   (RW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int              n_checks = 0;
  int              n_fail   = 0;
  logic [RW-1:0]   exp_q[$];
  logic [RW-1:0]   exp_ret;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at a negedge in FETCH with mem_req already up.
  task automatic reset_and_start(input logic ready);
    reset           = 1'b0;
    bus.mem_ready   = ready;
    bus.zero_flag   = 1'b0;
    bus.instruction = 32'h0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Runs one instruction from its FETCH cycle until retired moves.
  task automatic run_instr(input string tag, input logic [31:0] instr, input logic zf,
                           input int rd_wait, output int lat, output int rw,
                           output int m2r, output int held, output int pcw,
                           output int pcs, output int alu);
    logic [RW-1:0] start;
    int            memcyc;
    bit            done;
    bus.instruction = instr;
    bus.zero_flag   = zf;
    start  = bus.retired;
    lat = 0; rw = 0; m2r = 0; held = 0; pcw = -1; pcs = -1; alu = -1;
    memcyc = 0;
    done   = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      lat++;
      if (state_dbg == ST_MEM_RD || state_dbg == ST_MEM_WR) begin
        memcyc++;
        bus.mem_ready = (memcyc > rd_wait);
      end else begin
        bus.mem_ready = 1'b1;
      end
      #1;
      if (bus.RegWrite) rw++;
      if (bus.MemtoReg) m2r++;
      if ((state_dbg == ST_MEM_RD || state_dbg == ST_MEM_WR) && bus.mem_req && bus.IorD &&
          (bus.mem_we == (state_dbg == ST_MEM_WR))) held++;
      if (state_dbg == ST_BRANCH || state_dbg == ST_JAL) begin
        pcw = int'(bus.pc_write);
        pcs = int'(bus.pc_src);
      end
      if (state_dbg == ST_EXEC_R || state_dbg == ST_EXEC_I) alu = int'(bus.ALUControl);
      tick();
      if (bus.retired != start) done = 1'b1;
    end
    check_eq({tag, "_retire_bound"}, 32'(done), 32'd1);
  endtask

  task automatic trap_hold(input string tag);
    int strobes = 0;
    bus.mem_ready = 1'b1;
    repeat (100) begin
      tick();
      if (bus.mem_req || bus.ir_write || bus.pc_write || bus.RegWrite ||
          bus.mem_we || bus.MemtoReg) strobes++;
    end
    check_eq({tag, "_strobes"}, 32'(strobes), 32'd0);
    check_eq({tag, "_state"}, 32'(state_dbg), 32'(ST_TRAP));
    check_eq({tag, "_fault"}, 32'(bus.fault), 32'd1);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        zf;
    int          lat;
    int          rw;
    int          m2r;
    int          alu;
    int          pcw;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{"add",    I_ADD,        1'b0, 4, 1, 0, 2, -1};
    vecs[1]  = '{"sub",    32'h402081B3, 1'b0, 4, 1, 0, 6, -1};
    vecs[2]  = '{"addi30", 32'h40008093, 1'b0, 4, 1, 0, 2, -1};
    vecs[3]  = '{"xori30", 32'h4000C093, 1'b0, 4, 1, 0, 3, -1};
    vecs[4]  = '{"srai",   32'h4030D093, 1'b0, 4, 1, 0, 8, -1};
    vecs[5]  = '{"srl",    32'h0020D1B3, 1'b0, 4, 1, 0, 5, -1};
    vecs[6]  = '{"sll",    32'h002091B3, 1'b0, 4, 1, 0, 4, -1};
    vecs[7]  = '{"slt",    32'h0020A1B3, 1'b0, 4, 1, 0, 7, -1};
    vecs[8]  = '{"or",     32'h0020E1B3, 1'b0, 4, 1, 0, 1, -1};
    vecs[9]  = '{"and",    32'h0020F1B3, 1'b0, 4, 1, 0, 0, -1};
    vecs[10] = '{"lw",     I_LW,         1'b0, 5, 1, 1, -1, -1};
    vecs[11] = '{"sw",     I_SW,         1'b0, 4, 0, 0, -1, -1};
    vecs[12] = '{"beq_z1", I_BEQ,        1'b1, 3, 0, 0, -1, 1};
    vecs[13] = '{"beq_z0", I_BEQ,        1'b0, 3, 0, 0, -1, 0};
    vecs[14] = '{"bne_z1", I_BNE,        1'b1, 3, 0, 0, -1, 0};
    vecs[15] = '{"bne_z0", I_BNE,        1'b0, 3, 0, 0, -1, 1};
    vecs[16] = '{"jal",    I_JAL,        1'b0, 3, 1, 0, -1, 1};
  end

  // Watchdog: a hung run still reports.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, rw, m2r, held, pcw, pcs, alu, cnt;

    // Reset state (mem_ready high throughout must be ignored).
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    bus.zero_flag = 1'b0;
    bus.instruction = I_ADD;
    tick();
    check_eq("rst_state",    32'(state_dbg), 32'(ST_FETCH));
    check_eq("rst_mem_req",  32'(bus.mem_req), 32'd0);
    check_eq("rst_regwrite", 32'(bus.RegWrite), 32'd0);
    check_eq("rst_alu",      32'(bus.ALUControl), 32'd0);
    check_eq("rst_retired",  32'(bus.retired), 32'd0);
    check_eq("rst_fault",    32'({bus.fault, bus.fault_code}), 32'd0);
    check_eq("rst_irwrite",  32'(bus.ir_write), 32'd0);
    reset = 1'b1;
    #1;
    check_eq("rel_irwrite_noreq", 32'(bus.ir_write), 32'd0);
    tick();
    check_eq("fetch_mem_req", 32'(bus.mem_req), 32'd1);
    check_eq("fetch_srcs", 32'({bus.IorD, bus.alu_src_a, bus.alu_src_b}), 32'b0001);
    check_eq("fetch_alu", 32'(bus.ALUControl), 32'(ALU_ADD));
    check_eq("fetch_irwrite", 32'(bus.ir_write), 32'd1);
    check_eq("fetch_pcwrite", 32'({bus.pc_write, bus.pc_src}), 32'b100);

    // Vector table, retired tracked through the expected queue.
    exp_ret = '0;
    foreach (vecs[i]) begin
      exp_ret = exp_ret + 1'b1;
      exp_q.push_back(exp_ret);
      run_instr(vecs[i].name, vecs[i].instr, vecs[i].zf, 0, lat, rw, m2r, held, pcw, pcs, alu);
      check_eq({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      check_eq({vecs[i].name, "_regwrite"}, 32'(rw), 32'(vecs[i].rw));
      check_eq({vecs[i].name, "_memtoreg"}, 32'(m2r), 32'(vecs[i].m2r));
      if (vecs[i].alu >= 0) check_eq({vecs[i].name, "_alu"}, 32'(alu), 32'(vecs[i].alu));
      if (vecs[i].pcw >= 0) begin
        check_eq({vecs[i].name, "_pcwrite"}, 32'(pcw), 32'(vecs[i].pcw));
        check_eq({vecs[i].name, "_pcsrc"}, 32'(pcs), 32'(PC_SRC_ALUOUT));
      end
      check_eq({vecs[i].name, "_retired"}, 32'(bus.retired), 32'(exp_q.pop_front()));
    end

    // LW with 3 wait states in MEM_RD, SW with 2 in MEM_WR.
    run_instr("lw_wait", I_LW, 1'b0, 3, lat, rw, m2r, held, pcw, pcs, alu);
    check_eq("lw_wait_lat", 32'(lat), 32'd8);
    check_eq("lw_wait_held", 32'(held), 32'd4);
    check_eq("lw_wait_memtoreg", 32'(m2r), 32'd1);
    run_instr("sw_wait", I_SW, 1'b0, 2, lat, rw, m2r, held, pcw, pcs, alu);
    check_eq("sw_wait_lat", 32'(lat), 32'd6);
    check_eq("sw_wait_held", 32'(held), 32'd3);
    exp_ret = exp_ret + 2'd2;
    check_eq("after_wait_retired", 32'(bus.retired), 32'(exp_ret));

    // Reset while MEM_RD is waiting.
    bus.instruction = I_LW;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    bus.mem_ready = 1'b0;
    tick();
    check_eq("mrd_state", 32'(state_dbg), 32'(ST_MEM_RD));
    check_eq("mrd_mem_req", 32'(bus.mem_req), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("mrd_rst_mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("mrd_rst_state", 32'(state_dbg), 32'(ST_FETCH));
    check_eq("mrd_rst_retired", 32'(bus.retired), 32'd0);
    bus.mem_ready = 1'b1;
    cnt = 0;
    repeat (3) begin
      tick();
      if (bus.RegWrite || bus.pc_write || bus.ir_write) cnt++;
    end
    check_eq("mrd_rst_no_write", 32'(cnt), 32'd0);
    reset = 1'b1;
    tick();

    // 17 back-to-back addi wrap the 4-bit counter to 1.
    exp_ret = '0;
    repeat (17) begin
      exp_ret = exp_ret + 1'b1;
      exp_q.push_back(exp_ret);
      run_instr("addi_wrap", I_ADDI, 1'b0, 0, lat, rw, m2r, held, pcw, pcs, alu);
      check_eq("addi_wrap_retired", 32'(bus.retired), 32'(exp_q.pop_front()));
    end
    check_eq("wrap_final", 32'(bus.retired), 32'd1);

    // Branch with unsupported funct3 traps as illegal.
    bus.instruction = I_BBAD;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    check_eq("bbad_state", 32'(state_dbg), 32'(ST_BRANCH));
    check_eq("bbad_pcwrite", 32'(bus.pc_write), 32'd0);
    tick();
    check_eq("bbad_trap", 32'(state_dbg), 32'(ST_TRAP));
    check_eq("bbad_code", 32'({bus.fault, bus.fault_code}), 32'b101);
    check_eq("bbad_retired", 32'(bus.retired), 32'd1);
    trap_hold("bbad_hold");

    // Illegal opcode 0x7F.
    reset_and_start(1'b1);
    bus.instruction = I_ILL;
    tick();
    check_eq("ill_decode", 32'(state_dbg), 32'(ST_DECODE));
    tick();
    check_eq("ill_trap", 32'(state_dbg), 32'(ST_TRAP));
    check_eq("ill_code", 32'({bus.fault, bus.fault_code}), 32'b101);
    trap_hold("ill_hold");

    // Memory never ready: trap after exactly TMO waiting cycles.
    reset_and_start(1'b0);
    check_eq("tmo_first_req", 32'(bus.mem_req), 32'd1);
    repeat (TMO - 1) tick();
    check_eq("tmo_last_wait_fault", 32'(bus.fault), 32'd0);
    check_eq("tmo_last_wait_req", 32'(bus.mem_req), 32'd1);
    tick();
    check_eq("tmo_state", 32'(state_dbg), 32'(ST_TRAP));
    check_eq("tmo_code", 32'({bus.fault, bus.fault_code}), 32'b110);
    check_eq("tmo_req_drop", 32'(bus.mem_req), 32'd0);
    bus.mem_ready = 1'b1;
    repeat (3) tick();
    check_eq("tmo_sticky", 32'({bus.fault, bus.fault_code}), 32'b110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
